// File: rtl/uart_cfg_frame_ctrl.sv
// uart_cfg_frame_ctrl: parses HEADER/ADDR/DATA/CHK frames from the
// UART receive stream and writes DATA into a small config register bank.

module uart_cfg_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         NUM_REGS    = 4,
  parameter int         TIMEOUT_CYC = 60000
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  reg_we,
  output logic [3:0]            reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  frame_err,
  output logic                  busy,
  output logic [7:0]            frame_cnt,
  output logic [8*NUM_REGS-1:0] cfg_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0] NREGS = 9'(NUM_REGS);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [7:0]    cnt_q;
  logic [7:0]    bank_q [NUM_REGS];

  logic [7:0]    sum;
  logic          chk_ok;
  logic          addr_ok;
  logic          tmo_hit;

  // Checksum is the 8-bit wrapped sum; the full address byte is
  // range-checked so high bits cannot alias onto a valid register.
  assign sum     = addr_q + data_q;
  assign chk_ok  = (rx_data == sum);
  assign addr_ok = ({1'b0, addr_q} < NREGS);
  assign tmo_hit = (tmo_q == TMO_LAST) && !rx_valid;

  // Next-state, capture and pulse generation for the frame parser.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q + 1'b1;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    if (rx_valid || state_q == S_IDLE) begin
      tmo_d = '0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = S_CHK;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (chk_ok && addr_ok) begin
            state_d = S_COMMIT;
            we_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Parser state, timeout counter, captured bytes and output pulses.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Register bank and committed-frame counter, updated on COMMIT.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      cnt_q <= cnt_q + 8'd1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q[3:0] == 4'(i)) begin
          bank_q[i] <= data_q;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_out[8*g +: 8] = bank_q[g];
  end

  assign reg_we    = we_q;
  assign reg_addr  = addr_q[3:0];
  assign reg_wdata = data_q;
  assign frame_err = err_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

endmodule
